// File: rtl/mem_stage_ctrl_if.sv
// Bundle between the memory-stage controller and its environment (EX/MEM, data memory, MEM/WB).
// The optional out_err signal exists only when STACK_GUARD_EN is defined.
interface mem_stage_ctrl_if #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 12
);
    logic                       in_valid;
    logic [2:0]                 in_op;
    logic [ADDRESS_SPACE-1:0]   in_addr;
    logic [WORD_LENGTH-1:0]     in_data;
    logic [2*WORD_LENGTH-1:0]   in_pc;
    logic [2:0]                 in_rdst;
    logic                       stall;
    logic [ADDRESS_SPACE-1:0]   MAR;
    logic [WORD_LENGTH-1:0]     MDR_in;
    logic                       mem;
    logic                       rw;
    logic [WORD_LENGTH-1:0]     MDR_out;
    logic [ADDRESS_SPACE-1:0]   sp;
    logic                       out_valid;
    logic                       out_wb;
    logic [WORD_LENGTH-1:0]     out_data;
    logic [2:0]                 out_rdst;
    logic                       out_pc_load;
    logic [2*WORD_LENGTH-1:0]   out_pc;
`ifdef STACK_GUARD_EN
    logic                       out_err;
`endif

    // Environment side: upstream pipeline plus the data memory returning MDR_out.
    modport master (
        output in_valid, in_op, in_addr, in_data, in_pc, in_rdst, MDR_out,
        input  stall, MAR, MDR_in, mem, rw, sp,
               out_valid, out_wb, out_data, out_rdst, out_pc_load, out_pc
`ifdef STACK_GUARD_EN
        , input out_err
`endif
    );

    modport slave (
        input  in_valid, in_op, in_addr, in_data, in_pc, in_rdst, MDR_out,
        output stall, MAR, MDR_in, mem, rw, sp,
               out_valid, out_wb, out_data, out_rdst, out_pc_load, out_pc
`ifdef STACK_GUARD_EN
        , output out_err
`endif
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: decodes LOAD/STORE/PUSH/POP/CALL/RET, owns the stack pointer and
// sequences the data memory. Define STACK_GUARD_EN to suppress stack overflow/underflow accesses.
module mem_stage_ctrl #(
    parameter int                       WORD_LENGTH   = 16,
    parameter int                       ADDRESS_SPACE = 12,
    parameter logic [ADDRESS_SPACE-1:0] SP_INIT       = {ADDRESS_SPACE{1'b1}}
) (
    input logic              clk,
    input logic              reset,
    mem_stage_ctrl_if.slave  bus
);
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;
    localparam logic [2:0] OP_CALL  = 3'd5;
    localparam logic [2:0] OP_RET   = 3'd6;

    typedef enum logic [2:0] {IDLE, RD_WAIT, CALL_HI, RET_HI, RET_LO} state_t;

    state_t                     state, next_state;
    logic [ADDRESS_SPACE-1:0]   sp_q, sp_next, sp_inc, sp_dec;
    logic [WORD_LENGTH-1:0]     pc_hi, ret_hi;
    logic [2:0]                 rdst_q;
    logic                       accept, fault;
    logic                       mem_c, rw_c;
    logic [ADDRESS_SPACE-1:0]   mar_c;
    logic [WORD_LENGTH-1:0]     mdr_c;
    logic                       pulse, pulse_wb, pulse_pc;
    logic                       out_valid_q, out_wb_q, out_pc_load_q;
    logic [WORD_LENGTH-1:0]     out_data_q;
    logic [2:0]                 out_rdst_q;
    logic [2*WORD_LENGTH-1:0]   out_pc_q;

    assign sp_inc = sp_q + {{(ADDRESS_SPACE-1){1'b0}}, 1'b1};
    assign sp_dec = sp_q - {{(ADDRESS_SPACE-1){1'b0}}, 1'b1};
    assign accept = (state == IDLE) && bus.in_valid;

`ifdef STACK_GUARD_EN
    // A stack word that would cross either end of memory is dropped and the op ends with an error.
    assign fault = (((accept && (bus.in_op == OP_PUSH || bus.in_op == OP_CALL)) || state == CALL_HI)
                    && sp_q == '0)
                || (((accept && (bus.in_op == OP_POP || bus.in_op == OP_RET)) || state == RET_HI)
                    && sp_q == SP_INIT);
`else
    assign fault = 1'b0;
`endif

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next_state = state;
        sp_next    = sp_q;
        mem_c      = 1'b0;
        rw_c       = 1'b1;
        mar_c      = sp_q;
        mdr_c      = bus.in_data;
        pulse      = 1'b0;
        pulse_wb   = 1'b0;
        pulse_pc   = 1'b0;
        if (fault) begin
            pulse      = 1'b1;
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    case (bus.in_op)
                        OP_LOAD:  begin mem_c = 1'b1; mar_c = bus.in_addr; next_state = RD_WAIT; end
                        OP_STORE: begin mem_c = 1'b1; rw_c = 1'b0; mar_c = bus.in_addr; pulse = 1'b1; end
                        OP_PUSH:  begin mem_c = 1'b1; rw_c = 1'b0; sp_next = sp_dec; pulse = 1'b1; end
                        OP_POP:   begin
                            mem_c = 1'b1; mar_c = sp_inc; sp_next = sp_inc; next_state = RD_WAIT;
                        end
                        OP_CALL:  begin
                            mem_c = 1'b1; rw_c = 1'b0; mdr_c = bus.in_pc[WORD_LENGTH-1:0];
                            sp_next = sp_dec; next_state = CALL_HI;
                        end
                        OP_RET:   begin
                            mem_c = 1'b1; mar_c = sp_inc; sp_next = sp_inc; next_state = RET_HI;
                        end
                        default: ;
                    endcase
                end
                RD_WAIT: begin pulse = 1'b1; pulse_wb = 1'b1; next_state = IDLE; end
                CALL_HI: begin
                    mem_c = 1'b1; rw_c = 1'b0; mdr_c = pc_hi; sp_next = sp_dec;
                    pulse = 1'b1; next_state = IDLE;
                end
                RET_HI:  begin mem_c = 1'b1; mar_c = sp_inc; sp_next = sp_inc; next_state = RET_LO; end
                RET_LO:  begin pulse = 1'b1; pulse_pc = 1'b1; next_state = IDLE; end
                default: next_state = IDLE;
            endcase
        end
        // A reset cycle must not complete a pending second word of CALL/RET.
        if (reset) mem_c = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sp_q          <= SP_INIT;
            pc_hi         <= '0;
            ret_hi        <= '0;
            rdst_q        <= '0;
            out_valid_q   <= 1'b0;
            out_wb_q      <= 1'b0;
            out_pc_load_q <= 1'b0;
            out_data_q    <= '0;
            out_rdst_q    <= '0;
            out_pc_q      <= '0;
        end else begin
            state         <= next_state;
            sp_q          <= sp_next;
            out_valid_q   <= pulse;
            out_wb_q      <= pulse_wb;
            out_pc_load_q <= pulse_pc;
            if (accept) begin
                rdst_q <= bus.in_rdst;
                pc_hi  <= bus.in_pc[2*WORD_LENGTH-1:WORD_LENGTH];
            end
            if (state == RET_HI) ret_hi <= bus.MDR_out;
            if (pulse)    out_rdst_q <= (state == IDLE) ? bus.in_rdst : rdst_q;
            if (pulse_wb) out_data_q <= bus.MDR_out;
            if (pulse_pc) out_pc_q   <= {ret_hi, bus.MDR_out};
        end
    end

`ifdef STACK_GUARD_EN
    logic out_err_q;
    always_ff @(posedge clk) begin
        if (reset) out_err_q <= 1'b0;
        else       out_err_q <= fault;
    end
    assign bus.out_err = out_err_q;
`endif

    assign bus.stall       = (state != IDLE);
    assign bus.MAR         = mar_c;
    assign bus.MDR_in      = mdr_c;
    assign bus.mem         = mem_c;
    assign bus.rw          = rw_c;
    assign bus.sp          = sp_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_wb      = out_wb_q;
    assign bus.out_pc_load = out_pc_load_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_rdst    = out_rdst_q;
    assign bus.out_pc      = out_pc_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected results are queued when an op is issued and
// compared when out_valid pulses; memory writes are logged by a behavioural 1-cycle RAM.
module tb_mem_stage_ctrl;
    localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_STORE = 3'd2, OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP = 3'd4, OP_CALL = 3'd5, OP_RET = 3'd6, OP_RSV = 3'd7;

    typedef struct packed {
        logic        wb;
        logic        pc_load;
        logic        err;
        logic [15:0] data;
        logic [2:0]  rdst;
        logic [31:0] pc;
    } res_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];
    wr_t  wr_q[$];
    res_t e;
    logic [15:0] ram [4096];

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: synchronous read, data visible the cycle after issue.
    always @(posedge clk) begin
        if (bus.mem) begin
            if (bus.rw) bus.MDR_out <= ram[bus.MAR];
            else begin
                ram[bus.MAR] <= bus.MDR_in;
                wr_q.push_back({bus.MAR, bus.MDR_in});
            end
        end
    end

    // Result monitor: each out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            logic got_err;
`ifdef STACK_GUARD_EN
            got_err = bus.out_err;
`else
            got_err = 1'b0;
`endif
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result: got out_valid=1 with rdst=%0d, required no result", bus.out_rdst);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_wb, bus.out_pc_load, got_err, bus.out_rdst} !== {e.wb, e.pc_load, e.err, e.rdst}) begin
                    failures++;
                    $display("FAIL result_flags: got wb=%b pc_load=%b err=%b rdst=%0d, required wb=%b pc_load=%b err=%b rdst=%0d",
                             bus.out_wb, bus.out_pc_load, got_err, bus.out_rdst, e.wb, e.pc_load, e.err, e.rdst);
                end
                if (e.wb) begin
                    checks++;
                    if (bus.out_data !== e.data) begin
                        failures++;
                        $display("FAIL result_data: got %h, required %h", bus.out_data, e.data);
                    end
                end
                if (e.pc_load) begin
                    checks++;
                    if (bus.out_pc !== e.pc) begin
                        failures++;
                        $display("FAIL result_pc: got %h, required %h", bus.out_pc, e.pc);
                    end
                end
            end
        end
    end

    function automatic res_t mk_res(input logic wb, input logic pcl, input logic err,
                                    input logic [15:0] data, input logic [2:0] rdst, input logic [31:0] pc);
        res_t r;
        r.wb = wb; r.pc_load = pcl; r.err = err; r.data = data; r.rdst = rdst; r.pc = pc;
        return r;
    endfunction

    function automatic wr_t pop_wr();
        if (wr_q.size() == 0) return '1;
        return wr_q.pop_front();
    endfunction

    // Called at a negedge; holds the op until accepted, returns at the negedge after the accept edge.
    task automatic send_op(input logic [2:0] op, input logic [11:0] addr, input logic [15:0] data,
                           input logic [31:0] pc, input logic [2:0] rdst, output int waits);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_addr = addr;
        bus.in_data = data; bus.in_pc = pc; bus.in_rdst = rdst;
        waits = 0;
        while (bus.stall && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) begin
            checks++; failures++;
            $display("FAIL accept_timeout: op %0d still stalled after %0d cycles", op, waits);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = OP_NOP; bus.in_addr = '0;
        bus.in_data = '0; bus.in_pc = '0; bus.in_rdst = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.stall, bus.mem, bus.sp} !== {1'b0, 1'b0, 12'hFFF}) begin
            failures++;
            $display("FAIL reset_state: got stall=%b mem=%b sp=%h, required 0 0 fff", bus.stall, bus.mem, bus.sp);
        end
        checks++;
        if ({bus.out_valid, bus.out_wb, bus.out_pc_load, bus.out_data, bus.out_rdst, bus.out_pc} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b wb=%b pcl=%b data=%h rdst=%0d pc=%h, required all 0",
                     bus.out_valid, bus.out_wb, bus.out_pc_load, bus.out_data, bus.out_rdst, bus.out_pc);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.stall, bus.mem, bus.out_valid, bus.sp} !== {3'b000, 12'hFFF}) begin
            failures++;
            $display("FAIL post_reset_idle: got stall=%b mem=%b valid=%b sp=%h", bus.stall, bus.mem, bus.out_valid, bus.sp);
        end
    endtask

    task automatic test_store_load();
        int waits, lat;
        wr_t w;
        exp_q.push_back(mk_res(1'b0, 1'b0, 1'b0, 16'h0, 3'd1, 32'h0));
        send_op(OP_STORE, 12'h010, 16'hBEEF, 32'h0, 3'd1, waits);
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL store_stall: got %b, required 0", bus.stall); end
        wait_valid(lat);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL store_latency: got %0d, required 1", lat); end
        w = pop_wr();
        checks++;
        if (w !== {12'h010, 16'hBEEF}) begin failures++; $display("FAIL store_write: got %h, required 010beef", w); end
        exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, 16'hBEEF, 3'd2, 32'h0));
        send_op(OP_LOAD, 12'h010, 16'h0, 32'h0, 3'd2, waits);
        checks++;
        if (bus.stall !== 1'b1) begin failures++; $display("FAIL load_rd_wait_stall: got %b, required 1", bus.stall); end
        wait_valid(lat);
        checks++;
        if ({lat, bus.stall} !== {32'd2, 1'b0}) begin
            failures++; $display("FAIL load_latency: got lat=%0d stall=%b, required 2 0", lat, bus.stall);
        end
        checks++;
        if (wr_q.size() != 0) begin failures++; $display("FAIL load_no_write: got %0d writes, required 0", wr_q.size()); end
    endtask

    task automatic test_push_pop();
        int waits, lat;
        wr_t w;
        logic [15:0] vals [2];
        logic [11:0] addrs [2];
        vals[0] = 16'h1234; vals[1] = 16'h5678;
        addrs[0] = 12'hFFF; addrs[1] = 12'hFFE;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk_res(1'b0, 1'b0, 1'b0, 16'h0, 3'(i), 32'h0));
            send_op(OP_PUSH, 12'h0, vals[i], 32'h0, 3'(i), waits);
            wait_valid(lat);
            w = pop_wr();
            checks++;
            if ({lat, w, bus.sp} !== {32'd1, addrs[i], vals[i], 12'(addrs[i] - 12'd1)}) begin
                failures++;
                $display("FAIL push_%0d: got lat=%0d write=%h sp=%h, required lat=1 write=%h%h sp=%h",
                         i, lat, w, bus.sp, addrs[i], vals[i], 12'(addrs[i] - 12'd1));
            end
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, vals[1-i], 3'(3 + i), 32'h0));
            send_op(OP_POP, 12'h0, 16'h0, 32'h0, 3'(3 + i), waits);
            wait_valid(lat);
            checks++;
            if ({lat, bus.sp} !== {32'd2, addrs[1-i]}) begin
                failures++;
                $display("FAIL pop_%0d: got lat=%0d sp=%h, required lat=2 sp=%h", i, lat, bus.sp, addrs[1-i]);
            end
        end
    endtask

    task automatic test_call_ret();
        int waits, lat;
        wr_t w0, w1;
        exp_q.push_back(mk_res(1'b0, 1'b0, 1'b0, 16'h0, 3'd5, 32'h0));
        send_op(OP_CALL, 12'h0, 16'h0, 32'hCAFE0042, 3'd5, waits);
        wait_valid(lat);
        w0 = pop_wr();
        w1 = pop_wr();
        checks++;
        if ({lat, w0, w1, bus.sp} !== {32'd2, 12'hFFF, 16'h0042, 12'hFFE, 16'hCAFE, 12'hFFD}) begin
            failures++;
            $display("FAIL call: got lat=%0d w0=%h w1=%h sp=%h, required 2 fff0042 ffecafe ffd", lat, w0, w1, bus.sp);
        end
        exp_q.push_back(mk_res(1'b0, 1'b1, 1'b0, 16'h0, 3'd6, 32'hCAFE0042));
        send_op(OP_RET, 12'h0, 16'h0, 32'h0, 3'd6, waits);
        checks++;
        if (bus.stall !== 1'b1) begin failures++; $display("FAIL ret_stall: got %b, required 1", bus.stall); end
        wait_valid(lat);
        checks++;
        if ({lat, bus.sp, wr_q.size()} !== {32'd3, 12'hFFF, 32'd0}) begin
            failures++; $display("FAIL ret: got lat=%0d sp=%h writes=%0d, required 3 fff 0", lat, bus.sp, wr_q.size());
        end
    endtask

    task automatic test_reset_mid_call();
        int waits;
        wr_t w;
        send_op(OP_CALL, 12'h0, 16'h0, 32'h11112222, 3'd7, waits);
        checks++;
        if ({bus.stall, bus.sp} !== {1'b1, 12'hFFE}) begin
            failures++; $display("FAIL call_hi_entry: got stall=%b sp=%h, required 1 ffe", bus.stall, bus.sp);
        end
        reset = 1'b1;
        @(negedge clk);
        w = pop_wr();
        checks++;
        if ({w, 32'(wr_q.size())} !== {12'hFFF, 16'h2222, 32'd0}) begin
            failures++; $display("FAIL reset_abort_writes: got first=%h extra=%0d, required fff2222 0", w, wr_q.size());
        end
        checks++;
        if ({bus.stall, bus.mem, bus.sp, bus.out_valid, bus.out_wb, bus.out_pc_load,
             bus.out_data, bus.out_rdst, bus.out_pc} !== {2'b00, 12'hFFF, 3'b000, 16'h0, 3'd0, 32'h0}) begin
            failures++;
            $display("FAIL reset_abort_state: got stall=%b mem=%b sp=%h valid=%b data=%h rdst=%0d pc=%h",
                     bus.stall, bus.mem, bus.sp, bus.out_valid, bus.out_data, bus.out_rdst, bus.out_pc);
        end
        reset = 1'b0;
    endtask

    task automatic test_stall_hold();
        int waits, lat;
        wr_t w;
        exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, 16'hBEEF, 3'd1, 32'h0));
        exp_q.push_back(mk_res(1'b0, 1'b0, 1'b0, 16'h0, 3'd2, 32'h0));
        send_op(OP_LOAD, 12'h010, 16'h0, 32'h0, 3'd1, waits);
        send_op(OP_PUSH, 12'h0, 16'h9999, 32'h0, 3'd2, waits);
        wait_valid(lat);
        w = pop_wr();
        checks++;
        if ({waits, lat, w, bus.sp, 32'(wr_q.size())} !== {32'd1, 32'd1, 12'hFFF, 16'h9999, 12'hFFE, 32'd0}) begin
            failures++;
            $display("FAIL stall_hold_push: got waits=%0d lat=%0d write=%h sp=%h extra=%0d, required 1 1 fff9999 ffe 0",
                     waits, lat, w, bus.sp, wr_q.size());
        end
        exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, 16'h9999, 3'd3, 32'h0));
        send_op(OP_POP, 12'h0, 16'h0, 32'h0, 3'd3, waits);
        wait_valid(lat);
        checks++;
        if (bus.sp !== 12'hFFF) begin failures++; $display("FAIL stall_hold_restore_sp: got %h, required fff", bus.sp); end
    endtask

    task automatic test_back_to_back();
        int waits, lat;
        wr_t w0, w1;
        exp_q.push_back(mk_res(1'b0, 1'b0, 1'b0, 16'h0, 3'd1, 32'h0));
        exp_q.push_back(mk_res(1'b0, 1'b0, 1'b0, 16'h0, 3'd2, 32'h0));
        send_op(OP_STORE, 12'h020, 16'h1111, 32'h0, 3'd1, waits);
        send_op(OP_STORE, 12'h021, 16'h2222, 32'h0, 3'd2, waits);
        w0 = pop_wr();
        w1 = pop_wr();
        checks++;
        if ({waits, bus.out_valid, w0, w1} !== {32'd0, 1'b1, 12'h020, 16'h1111, 12'h021, 16'h2222}) begin
            failures++;
            $display("FAIL back_to_back: got waits=%0d valid=%b w0=%h w1=%h, required 0 1 0201111 0212222",
                     waits, bus.out_valid, w0, w1);
        end
        send_op(OP_NOP, 12'h022, 16'h3333, 32'h0, 3'd3, waits);
        send_op(OP_RSV, 12'h023, 16'h4444, 32'h0, 3'd3, waits);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL nop_no_result: got valid=1 at cycle %0d", i); end
            @(negedge clk);
        end
        checks++;
        if ({32'(wr_q.size()), bus.sp} !== {32'd0, 12'hFFF}) begin
            failures++; $display("FAIL nop_no_access: got writes=%0d sp=%h, required 0 fff", wr_q.size(), bus.sp);
        end
        exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, 16'h2222, 3'd4, 32'h0));
        send_op(OP_LOAD, 12'h021, 16'h0, 32'h0, 3'd4, waits);
        wait_valid(lat);
    endtask

    task automatic test_pop_empty();
        int waits, lat;
        wr_t w;
        exp_q.push_back(mk_res(1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 32'h0));
        send_op(OP_STORE, 12'h000, 16'hA5A5, 32'h0, 3'd0, waits);
        wait_valid(lat);
        w = pop_wr();
`ifdef STACK_GUARD_EN
        exp_q.push_back(mk_res(1'b0, 1'b0, 1'b1, 16'h0, 3'd5, 32'h0));
        send_op(OP_POP, 12'h0, 16'h0, 32'h0, 3'd5, waits);
        wait_valid(lat);
        checks++;
        if ({lat, bus.sp, bus.stall} !== {32'd1, 12'hFFF, 1'b0}) begin
            failures++; $display("FAIL pop_guard: got lat=%0d sp=%h stall=%b, required 1 fff 0", lat, bus.sp, bus.stall);
        end
`else
        exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, 16'hA5A5, 3'd5, 32'h0));
        send_op(OP_POP, 12'h0, 16'h0, 32'h0, 3'd5, waits);
        wait_valid(lat);
        checks++;
        if ({lat, bus.sp} !== {32'd2, 12'h000}) begin
            failures++; $display("FAIL pop_wrap: got lat=%0d sp=%h, required 2 000", lat, bus.sp);
        end
        exp_q.push_back(mk_res(1'b0, 1'b0, 1'b0, 16'h0, 3'd6, 32'h0));
        send_op(OP_PUSH, 12'h0, 16'h0BAD, 32'h0, 3'd6, waits);
        wait_valid(lat);
        w = pop_wr();
        checks++;
        if ({w, bus.sp} !== {12'h000, 16'h0BAD, 12'hFFF}) begin
            failures++; $display("FAIL push_wrap: got write=%h sp=%h, required 0000bad fff", w, bus.sp);
        end
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_push_pop();
        test_call_ret();
        test_reset_mid_call();
        test_stall_hold();
        test_back_to_back();
        test_pop_empty();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending results and %0d unchecked writes, required 0 0", exp_q.size(), wr_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
